// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: multi-cycle W-bit A - B - BIN, one SLICE-bit slice per clock.
// Ports: clk, rst_n (async, active-low); start/a/b/bin capture an operation when not busy;
// busy is high while slices compute; done pulses one cycle when diff/bout/zero/ovf update.
module nibble_serial_subtractor #(
  parameter int W = 8,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);
  localparam int NSLICE = W / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [W-1:0] op_a, op_b, acc, res;
  logic carry, accept, last, cin_msb;
  logic [IW-1:0] idx;
  logic [SLICE-1:0] a_s, b_n;
  logic [SLICE:0] sum;
  // Subtraction as a + ~b + carry; carry register holds the inverted borrow.
  always_comb begin
    a_s = op_a[idx*SLICE +: SLICE];
    b_n = ~op_b[idx*SLICE +: SLICE];
    sum = {1'b0, a_s} + {1'b0, b_n} + {{SLICE{1'b0}}, carry};
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    cin_msb = a_s[SLICE-1] ^ b_n[SLICE-1] ^ sum[SLICE-1];
    res = acc;
    res[idx*SLICE +: SLICE] = sum[SLICE-1:0];
  end
  assign accept = start && state != RUN;
  assign last = idx == IW'(NSLICE - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      acc <= '0;
      carry <= 1'b0;
      idx <= '0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      state <= RUN;
      op_a <= a;
      op_b <= b;
      carry <= ~bin;
      idx <= '0;
    end else if (state == RUN) begin
      acc <= res;
      carry <= sum[SLICE];
      idx <= idx + IW'(1);
      if (last) begin
        state <= DONE;
        diff <= res;
        bout <= ~sum[SLICE];
        zero <= res == '0;
        ovf <= cin_msb ^ sum[SLICE];
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed table, handshake sequences and random checks at W=8 and W=16.
module tb_nibble_serial_subtractor;
  logic clk = 0, rst_n = 0, start = 0, bin = 0;
  logic [7:0] a = 0, b = 0, diff;
  logic busy, done, bout, zero, ovf;
  logic start16 = 0, bin16 = 0;
  logic [15:0] a16 = 0, b16 = 0, diff16;
  logic busy16, done16, bout16, zero16, ovf16;
  int n_cmp = 0, n_fail = 0;

  nibble_serial_subtractor #(.W(8), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf));

  nibble_serial_subtractor #(.W(16), .SLICE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .zero(zero16), .ovf(ovf16));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic bin;
    logic [7:0] d;
    logic bo, z, v;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Launch one operation on either instance and return at the negedge where done is seen.
  task automatic do_op(input bit wide, input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                       output int lat, output int bc);
    @(negedge clk);
    if (wide) begin a16 = ta; b16 = tb; bin16 = tbin; start16 = 1; end
    else begin a = ta[7:0]; b = tb[7:0]; bin = tbin; start = 1; end
    @(posedge clk);
    #1 start = 0; start16 = 0;
    lat = 0; bc = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (wide ? busy16 : busy) bc++;
      if (wide ? done16 : done) break;
    end
  endtask

  task automatic rand8(input int i);
    logic [7:0] ra, rb;
    logic rbin;
    logic [8:0] full;
    int s, lat, bc;
    ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
    full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
    s = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    do_op(0, {8'd0, ra}, {8'd0, rb}, rbin, lat, bc);
    chk($sformatf("r8_%0d_lat", i), lat, 3);
    chk($sformatf("r8_%0d_res", i), {diff, bout, zero, ovf},
        {full[7:0], full[8], full[7:0] == 0, s < -128 || s > 127});
  endtask

  task automatic rand16(input int i);
    logic [15:0] ra, rb;
    logic rbin;
    logic [16:0] full;
    int s, lat, bc;
    ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
    full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
    s = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    do_op(1, ra, rb, rbin, lat, bc);
    chk($sformatf("r16_%0d_lat", i), lat, 5);
    chk($sformatf("r16_%0d_busy", i), bc, 4);
    chk($sformatf("r16_%0d_res", i), {diff16, bout16, zero16, ovf16},
        {full[15:0], full[16], full[15:0] == 0, s < -32768 || s > 32767});
  endtask

  initial begin
    int lat, bc;
    bit seen;
    tv[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
    tv[2] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tv[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    tv[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    tv[5] = '{8'h05, 8'h04, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    tv[6] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    tv[7] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tv[8] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tv[9] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
    #1;
    chk("reset_outputs", {busy, done, diff, bout, zero, ovf}, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      do_op(0, {8'd0, tv[i].a}, {8'd0, tv[i].b}, tv[i].bin, lat, bc);
      chk($sformatf("v%0d_lat", i), lat, 3);
      chk($sformatf("v%0d_busy", i), bc, 2);
      chk($sformatf("v%0d_diff", i), diff, tv[i].d);
      chk($sformatf("v%0d_flags", i), {bout, zero, ovf}, {tv[i].bo, tv[i].z, tv[i].v});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 0; start = 1;
    @(posedge clk);
    #1 a = 8'hFF; b = 8'h01; bin = 1;
    @(posedge clk);
    #1 start = 0;
    lat = 0;
    while (lat < 10 && !done) begin @(negedge clk); lat++; end
    chk("ignore_busy_lat", lat, 2);
    chk("ignore_busy_res", {diff, bout, zero, ovf}, {8'h23, 3'b000});
    do_op(0, 16'h50, 16'h20, 0, lat, bc);
    chk("b2b_first", diff, 8'h30);
    a = 8'h44; b = 8'h11; bin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("b2b_no_gap", {busy, done}, 2'b10);
    chk("b2b_hold", diff, 8'h30);
    @(negedge clk);
    chk("b2b_busy2", busy, 1);
    @(negedge clk);
    chk("b2b_second", {done, diff}, {1'b1, 8'h33});
    do_op(0, 16'h80, 16'h01, 0, lat, bc);
    chk("pre_reset", {diff, ovf}, {8'h7F, 1'b1});
    @(negedge clk);
    a = 8'h22; b = 8'h11; bin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("mid_run_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_run_reset", {busy, done, diff, bout, zero, ovf}, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (done || busy) seen = 1; end
    chk("no_done_after_reset", seen, 0);
    for (int i = 0; i < 200; i++) rand8(i);
    do_op(1, 16'h1000, 16'h0001, 0, lat, bc);
    chk("w16_lat", lat, 5);
    chk("w16_busy", bc, 4);
    chk("w16_borrow_chain", {diff16, bout16, zero16, ovf16}, {16'h0FFF, 3'b000});
    do_op(1, 16'h8000, 16'h0001, 0, lat, bc);
    chk("w16_ovf", {diff16, bout16, zero16, ovf16}, {16'h7FFF, 3'b001});
    do_op(1, 16'h0000, 16'hFFFF, 1, lat, bc);
    chk("w16_zero", {diff16, bout16, zero16, ovf16}, {16'h0000, 3'b110});
    for (int i = 0; i < 20; i++) rand16(i);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
